// File: rtl/modulation_pkg.sv
// Shared types and default widths for the modulation address sequencer.
package modulation_pkg;

  localparam int unsigned ADDR_DEF_W = 16;
  localparam int unsigned DIV_DEF_W  = 32;

  typedef logic [ADDR_DEF_W-1:0] addr_t;
  typedef logic [DIV_DEF_W-1:0]  div_t;

  typedef enum logic {
    MODE_LOOP     = 1'b0,
    MODE_ONE_SHOT = 1'b1
  } mode_e;

  // Sequencer run state: idle until first SYNC, running, or one-shot finished.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/modulation_divider.sv
// Clock divider: emits a tick on the edge where the count completes a period.
module modulation_divider
  import modulation_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_DEF_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_cycle,
  output logic             o_tick_c
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_last;

  // A period of zero behaves as a period of one.
  assign w_last   = (i_cycle == '0) ? '0 : (i_cycle - DIV_W'(1));
  assign o_tick_c = i_en && (r_cnt == w_last);

  // Count enabled edges; clear on realign or at the end of each period.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tick_c ? '0 : (r_cnt + DIV_W'(1));
    end
  end

endmodule

// File: rtl/modulation_sequencer.sv
// Steps a modulation-RAM read address on divider ticks, with sync, loop/one-shot and shadowed config.
module modulation_sequencer
  import modulation_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_DEF_W,
  parameter int unsigned DIV_W  = DIV_DEF_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_sync,
  input  logic              i_enable,
  input  logic              i_one_shot,
  input  logic [ADDR_W-1:0] i_mod_cycle,
  input  logic [DIV_W-1:0]  i_update_cycle,
  output logic              o_update,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_wrap,
  output logic              o_done
);

  state_e            r_state,  w_state;
  logic [ADDR_W-1:0] r_addr,   w_addr;
  logic              r_update, w_update;
  logic              r_wrap,   w_wrap;
  logic              r_done,   w_done;
  logic [ADDR_W-1:0] r_mod_s,  w_mod_s;
  logic [DIV_W-1:0]  r_cyc_s,  w_cyc_s;
  mode_e             r_os_s,   w_os_s;
  logic              w_load;
  logic              w_div_en;
  logic              w_tick;

  assign w_div_en = i_enable && (r_state == ST_RUN);

  modulation_divider #(
    .DIV_W(DIV_W)
  ) u_divider (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (i_sync),
    .i_en     (w_div_en),
    .i_cycle  (r_cyc_s),
    .o_tick_c (w_tick)
  );

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_update <= 1'b0;
      r_wrap   <= 1'b0;
      r_done   <= 1'b0;
      r_mod_s  <= '0;
      r_cyc_s  <= '0;
      r_os_s   <= MODE_LOOP;
    end else begin
      r_state  <= w_state;
      r_addr   <= w_addr;
      r_update <= w_update;
      r_wrap   <= w_wrap;
      r_done   <= w_done;
      r_mod_s  <= w_mod_s;
      r_cyc_s  <= w_cyc_s;
      r_os_s   <= w_os_s;
    end
  end

  // Next-state: SYNC dominates; otherwise advance the address on each divider tick.
  always_comb begin
    w_state  = r_state;
    w_addr   = r_addr;
    w_update = 1'b0;
    w_wrap   = 1'b0;
    w_done   = r_done;
    w_load   = 1'b0;
    w_mod_s  = r_mod_s;
    w_cyc_s  = r_cyc_s;
    w_os_s   = r_os_s;

    if (i_sync) begin
      w_state = ST_RUN;
      w_addr  = '0;
      w_done  = 1'b0;
      w_load  = 1'b1;
    end else if (w_tick) begin
      if (r_addr < r_mod_s) begin
        w_addr   = r_addr + ADDR_W'(1);
        w_update = 1'b1;
      end else if (r_os_s == MODE_LOOP) begin
        w_addr   = '0;
        w_update = 1'b1;
        w_wrap   = 1'b1;
        w_load   = 1'b1;
      end else begin
        w_state = ST_DONE;
        w_done  = 1'b1;
      end
    end

    if (w_load) begin
      w_mod_s = i_mod_cycle;
      w_cyc_s = i_update_cycle;
      w_os_s  = i_one_shot ? MODE_ONE_SHOT : MODE_LOOP;
    end
  end

  assign o_update = r_update;
  assign o_addr   = r_addr;
  assign o_wrap   = r_wrap;
  assign o_done   = r_done;

endmodule

// File: tb/tb_modulation_sequencer.sv
// Randomised and directed bench for modulation_sequencer with a queue-based scoreboard.
module tb_modulation_sequencer;

  logic        clk;
  logic        rst_n;
  logic        sync;
  logic        enable;
  logic        one_shot;
  logic [15:0] mod_cycle;
  logic [31:0] update_cycle;
  logic        update;
  logic [15:0] addr;
  logic        wrap;
  logic        done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          upd;
    logic [15:0] addr;
    bit          wrap;
    bit          done;
  } exp_t;

  exp_t exp_q[$];

  modulation_sequencer dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_sync         (sync),
    .i_enable       (enable),
    .i_one_shot     (one_shot),
    .i_mod_cycle    (mod_cycle),
    .i_update_cycle (update_cycle),
    .o_update       (update),
    .o_addr         (addr),
    .o_wrap         (wrap),
    .o_done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: plain integers, rules applied per clock edge.
  longint unsigned m_cnt, m_cyc, m_mod;
  int  m_addr;
  bit  m_os, m_run, m_done, m_upd, m_wrap;

  function automatic exp_t snap();
    exp_t e;
    e.upd  = m_upd;
    e.addr = 16'(m_addr);
    e.wrap = m_wrap;
    e.done = m_done;
    return e;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_cyc = 0; m_mod = 0; m_addr = 0;
    m_os = 0; m_run = 0; m_done = 0; m_upd = 0; m_wrap = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
      exp_q.delete();
      exp_q.push_back(snap());
    end else begin
      m_upd  = 0;
      m_wrap = 0;
      if (sync) begin
        m_cnt = 0; m_addr = 0; m_done = 0; m_run = 1;
        m_mod = mod_cycle; m_cyc = update_cycle; m_os = one_shot;
      end else if (enable && m_run) begin
        if (m_cnt + 1 >= ((m_cyc == 0) ? 1 : m_cyc)) begin
          m_cnt = 0;
          if (m_addr < m_mod) begin
            m_addr++;
            m_upd = 1;
          end else if (!m_os) begin
            m_addr = 0; m_upd = 1; m_wrap = 1;
            m_mod = mod_cycle; m_cyc = update_cycle; m_os = one_shot;
          end else begin
            m_done = 1; m_run = 0;
          end
        end else begin
          m_cnt++;
        end
      end
      exp_q.push_back(snap());
    end
  end

  // Monitor: compare DUT outputs with the latest expectation, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q[$];
      exp_q.delete();
      total++;
      if (update !== e.upd || addr !== e.addr || wrap !== e.wrap || done !== e.done) begin
        bad++;
        $display("FAIL scoreboard t=%0t: got upd=%b addr=%0d wrap=%b done=%b, want upd=%b addr=%0d wrap=%b done=%b",
                 $time, update, addr, wrap, done, e.upd, e.addr, e.wrap, e.done);
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_sync();
    sync = 1'b1;
    step(1);
    sync = 1'b0;
  endtask

  task automatic cfg(input bit os, input int md, input int cy);
    one_shot = os; mod_cycle = 16'(md); update_cycle = 32'(cy);
  endtask

  int seq4[7];

  initial begin
    rst_n = 1'b0; sync = 1'b0; enable = 1'b1;
    one_shot = 1'b0; mod_cycle = '0; update_cycle = '0;
    step(2);
    chk("reset_addr", addr, 0);
    chk("reset_update", update, 0);
    chk("reset_done", done, 0);
    rst_n = 1'b1;
    step(4);
    chk("pre_sync_no_update", update, 0);

    // 1: loop, period 4, last address 2
    cfg(0, 2, 4);
    do_sync();
    step(3);
    chk("t1_no_early_update", update, 0);
    step(1);
    chk("t1_upd4", update, 1); chk("t1_addr4", addr, 1);
    step(4); chk("t1_addr8", addr, 2);
    step(4); chk("t1_addr12", addr, 0); chk("t1_wrap12", wrap, 1);
    step(4); chk("t1_addr16", addr, 1); chk("t1_wrap16", wrap, 0);

    // 2: one-shot, last address 1, period 2
    cfg(1, 1, 2);
    do_sync();
    step(2); chk("t2_addr2", addr, 1);
    step(2); chk("t2_done4", done, 1); chk("t2_addr4", addr, 1); chk("t2_upd4", update, 0);
    step(6); chk("t2_hold_done", done, 1); chk("t2_hold_upd", update, 0);
    do_sync(); chk("t2_resync_done", done, 0); chk("t2_resync_addr", addr, 0);

    // 3: period 0 behaves as 1; last address 0 wraps every update
    cfg(0, 0, 0);
    do_sync();
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("t3_upd", update, 1); chk("t3_wrap", wrap, 1); chk("t3_addr", addr, 0);
    end

    // 4: shadowed last address only takes effect after the wrap
    cfg(0, 3, 1);
    do_sync();
    step(1); chk("t4_addr1", addr, 1);
    mod_cycle = 16'd1;
    seq4 = '{2, 3, 0, 1, 0, 1, 0};
    for (int i = 0; i < 7; i++) begin
      step(1);
      chk("t4_seq", addr, seq4[i]);
    end

    // 5: enable gating freezes the divider phase
    cfg(0, 7, 4);
    do_sync();
    step(2);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("t5_frozen_upd", update, 0); chk("t5_frozen_addr", addr, 0);
    end
    enable = 1'b1;
    step(1); chk("t5_resume1", update, 0);
    step(1); chk("t5_resume2", update, 1); chk("t5_resume_addr", addr, 1);

    // 6: asynchronous reset mid-run
    cfg(0, 3, 1);
    do_sync();
    step(2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_addr", addr, 0); chk("t6_async_done", done, 0);
    chk("t6_async_upd", update, 0); chk("t6_async_wrap", wrap, 0);
    step(2);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("t6_no_upd_before_sync", update, 0);
    end

    // Random phase checked entirely by the scoreboard
    for (int i = 0; i < 3000; i++) begin
      sync   = ($urandom_range(0, 99) < 3);
      enable = ($urandom_range(0, 99) < 85);
      if ($urandom_range(0, 9) == 0) begin
        one_shot     = ($urandom_range(0, 3) == 0);
        mod_cycle    = 16'($urandom_range(0, 5));
        update_cycle = 32'($urandom_range(0, 4));
      end
      step(1);
    end
    sync = 1'b0;
    step(2);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
